// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Input conditioning for the DIP-switch / seven-segment display path. The raw
// switch bus is brought into the cmosClock domain through a two-flop
// synchroniser. The whole synchronised bus must then hold one value for
// STABLE_CYCLES consecutive cycles before that value is committed to
// debouncedOut.
//
// Parameters:
//   WIDTH          number of switch bits
//   STABLE_CYCLES  cycles the synchronised bus must hold before commit
//                  (legal range 2 .. 2**COUNTER_WIDTH)
//   COUNTER_WIDTH  width of the stability counter
//   RESET_VALUE    reset value of the synchroniser, candidate and debouncedOut
//
// Ports:
//   cmosClock     in   system clock; all state changes on its rising edge
//   resetN        in   asynchronous active-low reset
//   rawSwitch     in   raw switch bus, asynchronous to cmosClock
//   debouncedOut  out  filtered switch value
//   changeStrobe  out  one-cycle pulse, coincident with a newly committed value
//   changedMask   out  bits that toggled at the last commit; held until the
//                      next commit
//   settling      out  high while a candidate value is being qualified. This
//                      is the registered view of the FSM state.
//   eventCount    out  saturating count of commits. This port exists only when
//                      SWITCH_DEBOUNCER_EVENT_COUNT_EN is defined.
//
// Output semantics: there is no handshake. changeStrobe is a single-cycle
// qualifier with no backpressure. debouncedOut and changedMask are already
// valid in the cycle in which changeStrobe is high.
//
// Optional feature macro: SWITCH_DEBOUNCER_EVENT_COUNT_EN
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int               WIDTH         = 8,
  parameter int               STABLE_CYCLES = 1000000,
  parameter int               COUNTER_WIDTH = 20,
  parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
  input  logic             cmosClock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] rawSwitch,
  output logic [WIDTH-1:0] debouncedOut,
  output logic             changeStrobe,
  output logic [WIDTH-1:0] changedMask,
  output logic             settling
`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
  ,
  output logic [15:0]      eventCount
`endif
);

  // The counter value at which a candidate has been stable long enough.
  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  state_t                   state;
  logic [WIDTH-1:0]         sync1;
  logic [WIDTH-1:0]         sync2;
  logic [WIDTH-1:0]         candidate;
  logic [COUNTER_WIDTH-1:0] count;

  // Plain two-flop synchroniser. No logic is placed between the stages, so
  // that sync1 has a full cycle to resolve metastability.
  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= rawSwitch;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      state        <= STABLE;
      candidate    <= RESET_VALUE;
      count        <= '0;
      debouncedOut <= RESET_VALUE;
      changeStrobe <= 1'b0;
      changedMask  <= '0;
      settling     <= 1'b0;
`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
      eventCount   <= '0;
`endif
    end else begin
      changeStrobe <= 1'b0;
      case (state)
        STABLE: begin
          if (sync2 != debouncedOut) begin
            candidate <= sync2;
            count     <= '0;
            state     <= SETTLING;
            settling  <= 1'b1;
          end
        end
        SETTLING: begin
          if (sync2 != candidate && sync2 == debouncedOut) begin
            // The bus bounced back to the committed value, so drop the candidate.
            count    <= '0;
            state    <= STABLE;
            settling <= 1'b0;
          end else if (sync2 != candidate) begin
            // A different value appeared, so qualify that value from scratch.
            candidate <= sync2;
            count     <= '0;
          end else if (count == LAST_COUNT) begin
            debouncedOut <= candidate;
            changedMask  <= debouncedOut ^ candidate;
            changeStrobe <= 1'b1;
            count        <= '0;
            state        <= STABLE;
            settling     <= 1'b0;
`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
            if (eventCount != 16'hFFFF) eventCount <= eventCount + 16'd1;
`endif
          end else begin
            count <= count + COUNTER_WIDTH'(1);
          end
        end
        default: begin
          state    <= STABLE;
          settling <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input conditioning stage that sits directly upstream of the DIP-switch / seven-segment display path.
- Takes the raw, asynchronous 8-bit DIP switch bus and synchronises it into cmosClock. It filters contact bounce with a whole-bus stability counter.
- Presents a clean, glitch-free byte plus a one-cycle change strobe and a per-bit change mask. The byte replaces the raw dipSwitch bus at the input of the display path.

Parameters:
- WIDTH, 8, number of switch bits.
- STABLE_CYCLES, 1000000, cycles the synchronised bus must hold unchanged before commit (10 ms at 100 MHz). Legal range: 2 to 2^COUNTER_WIDTH.
- COUNTER_WIDTH, 20, width of the stability counter.
- RESET_VALUE, 8'h00, value loaded into the synchroniser flops and debouncedOut on reset.

Ports:
- cmosClock  input  1  system clock; all state on its rising edge.
- resetN  input  1  asynchronous active-low reset.
- rawSwitch  input  WIDTH  raw switch bus; asynchronous to cmosClock.
- debouncedOut  output  WIDTH  filtered switch value.
- changeStrobe  output  1  one-cycle pulse on each commit.
- changedMask  output  WIDTH  XOR of old and new debouncedOut at the last commit; held until the next commit.
- settling  output  1  high while a candidate value is being qualified.

Behaviour:
- Reset (resetN low, asynchronous assert; release is synchronous to the system):
  - sync1, sync2, debouncedOut, candidate <= RESET_VALUE.
  - count <= 0; state <= STABLE.
  - changeStrobe = 0, changedMask = 0, settling = 0.
- Synchroniser: 2-flop chain per bit (sync1 <= rawSwitch; s = sync2 <= sync1). No logic between the flops.
- FSM, 2 states:
  - STABLE:
    - if s != debouncedOut: candidate <= s, count <= 0, go to SETTLING.
    - else remain.
  - SETTLING:
    - if s != candidate and s == debouncedOut: bounce returned to the old value. Go to STABLE, no strobe, count <= 0.
    - else if s != candidate: candidate <= s, count <= 0, stay (restart qualification).
    - else if count == STABLE_CYCLES-1: debouncedOut <= candidate, changedMask <= debouncedOut ^ candidate, changeStrobe <= 1 for exactly one cycle, go to STABLE.
    - else count <= count+1.
- settling = (state == SETTLING), registered.
- Latency: rawSwitch stable before edge E0 gives debouncedOut updated on edge E0+STABLE_CYCLES+2. changeStrobe is high in the cycle after that edge, coincident with the new debouncedOut.
- Counter never wraps. It is compared for equality and cleared on every restart and on commit.
- Multi-bit changes inside one qualification window commit together as one strobe, with all toggled bits set in changedMask.
- A change in the cycle after commit (STABLE sees s != debouncedOut) starts a new qualification immediately. Back-to-back strobes are separated by at least STABLE_CYCLES+1 cycles.
- Reset mid-SETTLING:
  - candidate discarded; no strobe.
  - debouncedOut returns to RESET_VALUE.
  - If rawSwitch differs from RESET_VALUE after release, a full qualification follows.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_EVENT_COUNT_EN.
- When defined:
  - Adds output port eventCount (16 bits).
  - eventCount increments on every changeStrobe and saturates at 16'hFFFF.
  - Reset to 0 by resetN.
  - Used for bounce/activity diagnostics on the display.
- When undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
- Bench overrides STABLE_CYCLES=4, RESET_VALUE=8'h00 for all tests.
- Reset hold: resetN low, rawSwitch=8'hFF -> debouncedOut=8'h00, changeStrobe=0, settling=0 throughout reset.
- Clean change: rawSwitch 8'h00->8'hA5 before edge E0 -> debouncedOut=8'hA5 after edge E0+6, changeStrobe high exactly one cycle, changedMask=8'hA5.
- Bounce: rawSwitch toggles bit0 0/1 every 2 cycles for 20 cycles, then holds 1 -> no strobe during toggling. Exactly one strobe ~6 cycles after the final hold, debouncedOut=8'h01.
- Glitch return: debouncedOut=8'h01; rawSwitch pulses to 8'h03 for 2 cycles, then back to 8'h01 -> settling rises then falls, no strobe, debouncedOut stays 8'h01.
- Reset mid-settle: rawSwitch=8'h0F, assert resetN low 2 cycles into SETTLING -> debouncedOut=8'h00 immediately. After release, commit 8'h0F within 6 cycles with changedMask=8'h0F.
- With SWITCH_DEBOUNCER_EVENT_COUNT_EN: force 3 clean commits -> eventCount=3. Preload near 16'hFFFF via forced commits -> eventCount holds at 16'hFFFF.
